// File: rtl/stage2_align_if.sv
// Operand bundle from the compare stage into the alignment pipe, plus its aligned result.
// The slave modport is the alignment block; the master modport is whoever feeds and consumes it.
interface stage2_align_if #(
  parameter int MAN_W = 24
);
  localparam int EXT_W = MAN_W + 3;

  logic             in_valid;
  logic             A_sign;
  logic             B_sign_eff;
  logic [7:0]       A_exp;
  logic [7:0]       B_exp;
  logic [MAN_W-1:0] A_man;
  logic [MAN_W-1:0] B_man;
  logic [7:0]       exp_diff;
  logic             A_bigger;
  logic             stall;
  logic             flush;

  logic             out_valid;
  logic             big_sign;
  logic             small_sign;
  logic [7:0]       exp_out;
  logic [EXT_W-1:0] big_man;
  logic [EXT_W-1:0] small_man;
  logic             eff_sub;
  logic             exact_cancel;

  modport master (
    output in_valid, A_sign, B_sign_eff, A_exp, B_exp, A_man, B_man,
           exp_diff, A_bigger, stall, flush,
    input  out_valid, big_sign, small_sign, exp_out, big_man, small_man,
           eff_sub, exact_cancel
  );

  modport slave (
    input  in_valid, A_sign, B_sign_eff, A_exp, B_exp, A_man, B_man,
           exp_diff, A_bigger, stall, flush,
    output out_valid, big_sign, small_sign, exp_out, big_man, small_man,
           eff_sub, exact_cancel
  );
endinterface

// File: rtl/stage2_align.sv
// FP add alignment: orders operands, right-shifts the smaller significand with sticky; 2-cycle latency.
// stall freezes both stages and outputs (upstream holds data); flush drops in-flight entries.
module stage2_align #(
  parameter int MAN_W = 24
) (
  input logic          clk,
  input logic          rst,
  stage2_align_if.slave bus
);
  localparam int EXT_W = MAN_W + 3;
  localparam int SH_W  = $clog2(EXT_W + 1);

  typedef struct packed {
    logic             big_sign;
    logic             small_sign;
    logic [7:0]       exp_out;
    logic [EXT_W-1:0] big_man;
    logic [EXT_W-1:0] small_man;
    logic [2:0]       res_shift;
    logic             eff_sub;
    logic             exact_cancel;
  } s1_t;

  typedef struct packed {
    logic             big_sign;
    logic             small_sign;
    logic [7:0]       exp_out;
    logic [EXT_W-1:0] big_man;
    logic [EXT_W-1:0] small_man;
    logic             eff_sub;
    logic             exact_cancel;
  } s2_t;

  logic             s1_vld;
  logic             s2_vld;
  s1_t              s1_q;
  s1_t              s1_nxt;
  s2_t              s2_q;
  s2_t              s2_nxt;

  logic             a_larger;
  logic [7:0]       big_exp;
  logic [7:0]       small_exp;
  logic [7:0]       shift_raw;
  logic [SH_W-1:0]  shift_sat;
  logic [SH_W-1:0]  coarse;
  logic [EXT_W-1:0] small_ext;
  logic [EXT_W-1:0] crs_mask;
  logic [EXT_W-1:0] small_crs;
  logic [EXT_W-1:0] res_mask;
  logic [EXT_W-1:0] small_fin;

  // S1: operand order, shift amount and the coarse (multiple-of-8) shift
  always_comb begin
    a_larger  = (bus.exp_diff != 8'd0) ? bus.A_bigger : !(bus.B_man > bus.A_man);
    big_exp   = a_larger ? bus.A_exp : bus.B_exp;
    small_exp = a_larger ? bus.B_exp : bus.A_exp;

    // a denormal smaller operand really sits at exponent 1
    if ((big_exp != 8'd0) && (small_exp == 8'd0) && (bus.exp_diff != 8'd0))
      shift_raw = bus.exp_diff - 8'd1;
    else
      shift_raw = bus.exp_diff;

    if (shift_raw >= 8'(EXT_W))
      shift_sat = SH_W'(EXT_W);
    else
      shift_sat = shift_raw[SH_W-1:0];

    coarse    = {shift_sat[SH_W-1:3], 3'b000};
    small_ext = {(a_larger ? bus.B_man : bus.A_man), 3'b000};
    crs_mask  = ~({EXT_W{1'b1}} << coarse);
    small_crs = small_ext >> coarse;
    small_crs[0] = small_crs[0] | (|(small_ext & crs_mask));

    s1_nxt              = '0;
    s1_nxt.big_sign     = a_larger ? bus.A_sign : bus.B_sign_eff;
    s1_nxt.small_sign   = a_larger ? bus.B_sign_eff : bus.A_sign;
    s1_nxt.exp_out      = big_exp;
    s1_nxt.big_man      = {(a_larger ? bus.A_man : bus.B_man), 3'b000};
    s1_nxt.small_man    = small_crs;
    s1_nxt.res_shift    = shift_sat[2:0];
    s1_nxt.eff_sub      = bus.A_sign ^ bus.B_sign_eff;
    s1_nxt.exact_cancel = (bus.A_sign ^ bus.B_sign_eff) &&
                          (bus.A_exp == bus.B_exp) && (bus.A_man == bus.B_man);
  end

  // S2: residual 0..7 shift, folding shifted-out bits into the sticky position
  always_comb begin
    res_mask  = ~({EXT_W{1'b1}} << s1_q.res_shift);
    small_fin = s1_q.small_man >> s1_q.res_shift;
    small_fin[0] = small_fin[0] | (|(s1_q.small_man & res_mask));

    s2_nxt              = '0;
    s2_nxt.big_sign     = s1_q.big_sign;
    s2_nxt.small_sign   = s1_q.small_sign;
    s2_nxt.exp_out      = s1_q.exp_out;
    s2_nxt.big_man      = s1_q.big_man;
    s2_nxt.small_man    = small_fin;
    s2_nxt.eff_sub      = s1_q.eff_sub;
    s2_nxt.exact_cancel = s1_q.exact_cancel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else begin
      if (bus.flush) begin
        s1_vld <= 1'b0;
        s2_vld <= 1'b0;
      end else if (!bus.stall) begin
        s1_vld <= bus.in_valid;
        s2_vld <= s1_vld;
      end
      if (!bus.stall) begin
        if (bus.in_valid)
          s1_q <= s1_nxt;
        if (s1_vld)
          s2_q <= s2_nxt;
      end
    end
  end

  assign bus.out_valid    = s2_vld;
  assign bus.big_sign     = s2_q.big_sign;
  assign bus.small_sign   = s2_q.small_sign;
  assign bus.exp_out      = s2_q.exp_out;
  assign bus.big_man      = s2_q.big_man;
  assign bus.small_man    = s2_q.small_man;
  assign bus.eff_sub      = s2_q.eff_sub;
  assign bus.exact_cancel = s2_q.exact_cancel;

endmodule

// File: tb/tb_stage2_align.sv
// Bench for stage2_align: vector table through a scoreboard, plus stall, flush and reset sequences.
module tb_stage2_align;
  localparam int MAN_W = 24;
  localparam int EXT_W = MAN_W + 3;
  localparam int NVEC  = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stage2_align_if #(.MAN_W(MAN_W)) bus();

  stage2_align #(.MAN_W(MAN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic             big_sign;
    logic             small_sign;
    logic [7:0]       exp_out;
    logic [EXT_W-1:0] big_man;
    logic [EXT_W-1:0] small_man;
    logic             eff_sub;
    logic             exact_cancel;
  } res_t;

  typedef struct {
    logic             a_sign;
    logic             b_sign;
    logic [7:0]       a_exp;
    logic [7:0]       b_exp;
    logic [MAN_W-1:0] a_man;
    logic [MAN_W-1:0] b_man;
    res_t             exp;
  } vec_t;

  vec_t vecs [NVEC];
  res_t sb [$];
  int   checks = 0;
  int   errors = 0;
  logic adv = 1'b0;

  function automatic vec_t mk(logic as, logic bs, logic [7:0] ae, logic [7:0] be,
                              logic [MAN_W-1:0] am, logic [MAN_W-1:0] bm,
                              logic bsg, logic ssg, logic [7:0] eo,
                              logic [EXT_W-1:0] bmo, logic [EXT_W-1:0] smo,
                              logic es, logic ec);
    vec_t v;
    v.a_sign = as;  v.b_sign = bs;
    v.a_exp  = ae;  v.b_exp  = be;
    v.a_man  = am;  v.b_man  = bm;
    v.exp.big_sign     = bsg;
    v.exp.small_sign   = ssg;
    v.exp.exp_out      = eo;
    v.exp.big_man      = bmo;
    v.exp.small_man    = smo;
    v.exp.eff_sub      = es;
    v.exp.exact_cancel = ec;
    return v;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r = {bus.big_sign, bus.small_sign, bus.exp_out, bus.big_man, bus.small_man,
         bus.eff_sub, bus.exact_cancel};
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx);
    bus.in_valid   = 1'b1;
    bus.A_sign     = vecs[idx].a_sign;
    bus.B_sign_eff = vecs[idx].b_sign;
    bus.A_exp      = vecs[idx].a_exp;
    bus.B_exp      = vecs[idx].b_exp;
    bus.A_man      = vecs[idx].a_man;
    bus.B_man      = vecs[idx].b_man;
    bus.A_bigger   = (vecs[idx].a_exp >= vecs[idx].b_exp);
    bus.exp_diff   = (vecs[idx].a_exp >= vecs[idx].b_exp) ? vecs[idx].a_exp - vecs[idx].b_exp
                                                          : vecs[idx].b_exp - vecs[idx].a_exp;
  endtask

  task automatic drive_push(input int idx);
    drive(idx);
    sb.push_back(vecs[idx].exp);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 40 && sb.size() != 0; n++) tick();
    check(name, sb.size(), 0);
  endtask

  // an output is consumed only on an edge where the pipe advanced
  always @(posedge clk) adv <= !bus.stall;

  always @(negedge clk) begin
    if (rst && bus.out_valid && adv) begin
      res_t got;
      res_t want;
      got = dut_res();
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h, required no output", got);
      end else begin
        want = sb.pop_front();
        check("scoreboard", got, want);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk(0,0,8'd127,8'd126,24'h800000,24'h800000, 0,0,8'd127,27'h4000000,27'h2000000,0,0);
    vecs[1]  = mk(0,0,8'd160,8'd130,24'h800000,24'h800001, 0,0,8'd160,27'h4000000,27'h0000001,0,0);
    vecs[2]  = mk(0,1,8'd100,8'd100,24'h800000,24'hC00000, 1,0,8'd100,27'h6000000,27'h4000000,1,0);
    vecs[3]  = mk(0,0,8'd1,  8'd0,  24'h800000,24'h400000, 0,0,8'd1,  27'h4000000,27'h2000000,0,0);
    vecs[4]  = mk(0,1,8'd130,8'd130,24'hA00000,24'hA00000, 0,1,8'd130,27'h5000000,27'h5000000,1,1);
    vecs[5]  = mk(1,0,8'd120,8'd124,24'h800001,24'hF00000, 0,1,8'd124,27'h7800000,27'h0400001,1,0);
    vecs[6]  = mk(0,0,8'd150,8'd141,24'hFFFFFF,24'h800100, 0,0,8'd150,27'h7FFFFF8,27'h0020004,0,0);
    vecs[7]  = mk(0,0,8'd200,8'd175,24'h800000,24'hFFFFFF, 0,0,8'd200,27'h4000000,27'h0000003,0,0);
    vecs[8]  = mk(1,1,8'd0,  8'd0,  24'h000010,24'h000020, 1,1,8'd0,  27'h0000100,27'h0000080,0,0);
    vecs[9]  = mk(0,0,8'd3,  8'd0,  24'h800000,24'h7FFFFF, 0,0,8'd3,  27'h4000000,27'h0FFFFFE,0,0);
    vecs[10] = mk(0,0,8'd28, 8'd0,  24'h800000,24'h000001, 0,0,8'd28, 27'h4000000,27'h0000001,0,0);
    vecs[11] = mk(1,1,8'd90, 8'd10, 24'h900000,24'h000000, 1,1,8'd90, 27'h4800000,27'h0000000,0,0);

    bus.in_valid = 1'b0; bus.A_sign = 1'b0; bus.B_sign_eff = 1'b0;
    bus.A_exp = '0; bus.B_exp = '0; bus.A_man = '0; bus.B_man = '0;
    bus.exp_diff = '0; bus.A_bigger = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;

    #2;
    check("reset_state", {bus.out_valid, dut_res()}, '0);
    tick();
    rst = 1'b1;
    tick();

    // first-entry latency
    drive_push(0);
    tick();
    bus.in_valid = 1'b0;
    check("latency_1", bus.out_valid, 1'b0);
    tick();
    check("latency_2", bus.out_valid, 1'b1);
    drain("drain_latency");

    // back-to-back table
    for (int i = 1; i < NVEC; i++) begin
      drive_push(i);
      tick();
    end
    bus.in_valid = 1'b0;
    drain("drain_table");

    // two in flight, stall 3 cycles with garbage offered upstream
    drive_push(1);
    tick();
    drive_push(2);
    tick();
    bus.stall = 1'b1;
    drive(11);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", bus.out_valid, 1'b1);
      check("stall_data", dut_res(), vecs[1].exp);
    end
    bus.stall    = 1'b0;
    bus.in_valid = 1'b0;
    drain("drain_stall");

    // flush together with stall drops everything in flight
    drive_push(4);
    tick();
    drive_push(5);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    check("flush_out_valid", bus.out_valid, 1'b0);
    sb.delete();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    repeat (4) tick();
    check("flush_quiet", bus.out_valid, 1'b0);

    // asynchronous reset with one entry at the output and one in S1
    drive_push(7);
    tick();
    drive_push(6);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("reset_async", {bus.out_valid, dut_res()}, '0);
    sb.delete();
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("reset_no_stale", bus.out_valid, 1'b0);
    drive_push(8);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("reset_first_accept", bus.out_valid, 1'b1);
    drain("drain_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
